// File: rtl/scan_decoder.sv
// N-to-2**N one-hot decoder with registered outputs: direct decode or timed scan of the outputs.
// Optional macro BLANK_GAP_EN inserts one blank cycle at the end of each scan dwell period.
module scan_decoder #(
    parameter int N          = 2,
    parameter int SCAN_COUNT = 2**N,
    parameter int DWELL      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e,
    input  logic              mode,
    input  logic [N-1:0]      x,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      code,
    output logic              valid,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N-1:0]  LAST_CODE = N'(SCAN_COUNT - 1);
    localparam logic [N-1:0]  ONE_CODE  = N'(1);
    localparam logic [CW-1:0] LAST_DW   = CW'(DWELL - 1);
    localparam logic [CW-1:0] ONE_DW    = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_y;
    logic [N-1:0]   r_code;
    logic           r_valid;
    logic           r_wrap;
    logic [CW-1:0]  r_dwell;

    logic           w_last_dwell;
    logic [N-1:0]   w_next_code;
    logic [CW-1:0]  w_next_dwell;

    if (SCAN_COUNT < 1 || SCAN_COUNT > W) begin : g_chk_count
        $error("scan_decoder: SCAN_COUNT must be in 1..2**N");
    end
`ifdef BLANK_GAP_EN
    if (DWELL < 2) begin : g_chk_dwell
        $error("scan_decoder: DWELL must be at least 2 when blanking is enabled");
    end
`else
    if (DWELL < 1) begin : g_chk_dwell
        $error("scan_decoder: DWELL must be at least 1");
    end
`endif

    function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
        onehot = {{(W-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign w_last_dwell = (r_dwell == LAST_DW);
    assign w_next_code  = (r_code == LAST_CODE) ? {N{1'b0}} : (r_code + ONE_CODE);
    assign w_next_dwell = r_dwell + ONE_DW;

    // Mode FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_dwell <= '0;
        end else if (!e) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_dwell <= '0;
        end else if (!mode) begin
            r_state <= DIRECT;
            r_y     <= onehot(x);
            r_code  <= x;
            r_valid <= 1'b1;
            r_wrap  <= 1'b0;
            r_dwell <= '0;
        end else if (r_state != SCAN) begin
            // Any entry into scan restarts at index 0 without a wrap pulse.
            r_state <= SCAN;
            r_y     <= onehot({N{1'b0}});
            r_code  <= '0;
            r_valid <= 1'b1;
            r_wrap  <= 1'b0;
            r_dwell <= '0;
        end else if (w_last_dwell) begin
            r_state <= SCAN;
            r_y     <= onehot(w_next_code);
            r_code  <= w_next_code;
            r_valid <= 1'b1;
            r_wrap  <= (r_code == LAST_CODE);
            r_dwell <= '0;
        end else begin
            r_state <= SCAN;
            r_code  <= r_code;
            r_wrap  <= 1'b0;
            r_dwell <= w_next_dwell;
`ifdef BLANK_GAP_EN
            // Blank the final cycle of each dwell period to avoid ghosting.
            if (w_next_dwell == LAST_DW) begin
                r_y     <= '0;
                r_valid <= 1'b0;
            end else begin
                r_y     <= onehot(r_code);
                r_valid <= 1'b1;
            end
`else
            r_y     <= onehot(r_code);
            r_valid <= 1'b1;
`endif
        end
    end

    assign y     = r_y;
    assign code  = r_code;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: vector table plus scan sequences, checked through an expected-value queue.
module tb_scan_decoder;

`ifdef BLANK_GAP_EN
    localparam int DWELL_B = 2;
`else
    localparam int DWELL_B = 1;
`endif

    logic       clk;
    logic       rst;
    logic       e;
    logic       mode;
    logic [1:0] x;

    logic [3:0] y_a;
    logic [1:0] code_a;
    logic       valid_a;
    logic       wrap_a;
    logic [3:0] y_b;
    logic [1:0] code_b;
    logic       valid_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;
    int next_id = 0;

    typedef struct {
        int         id;
        logic       sel;
        logic [3:0] y;
        logic [1:0] c;
        logic       v;
        logic       w;
    } exp_t;

    typedef struct {
        logic       r;
        logic       en;
        logic       m;
        logic [1:0] xx;
        logic [3:0] y;
        logic [1:0] c;
        logic       v;
        logic       w;
    } vec_t;

    typedef struct packed {
        logic [3:0] y;
        logic [1:0] c;
        logic       v;
        logic       w;
    } out_t;

    exp_t sb[$];
    exp_t cur;

    scan_decoder #(.N(2), .SCAN_COUNT(4), .DWELL(4)) u_dut_a (
        .clk(clk), .rst(rst), .e(e), .mode(mode), .x(x),
        .y(y_a), .code(code_a), .valid(valid_a), .wrap(wrap_a)
    );

    scan_decoder #(.N(2), .SCAN_COUNT(3), .DWELL(DWELL_B)) u_dut_b (
        .clk(clk), .rst(rst), .e(e), .mode(mode), .x(x),
        .y(y_b), .code(code_b), .valid(valid_b), .wrap(wrap_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs k cycles after scan entry, from the dwell/index timeline.
    function automatic out_t scan_exp(input int k, input int d, input int sc);
        out_t o;
        int   idx;
        int   ph;
        logic [3:0] one;
        idx   = (k / d) % sc;
        ph    = k % d;
        one   = 4'b0001;
        o.y   = one << idx;
        o.c   = idx[1:0];
        o.v   = 1'b1;
        o.w   = (k > 0) && (ph == 0) && (idx == 0);
`ifdef BLANK_GAP_EN
        if (ph == d - 1) begin
            o.y = 4'b0000;
            o.v = 1'b0;
        end
`endif
        return o;
    endfunction

    task automatic chk(input string nm, input int id, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s id=%0d: got %b, expected %b", nm, id, got, want);
        end
    endtask

    // Drive one cycle of stimulus and queue what the selected DUT must show after the next edge.
    task automatic step(input logic r, input logic en, input logic m, input logic [1:0] xx,
                        input logic sel, input logic [3:0] ey, input logic [1:0] ec,
                        input logic ev, input logic ew);
        exp_t it;
        @(negedge clk);
        rst  = r;
        e    = en;
        mode = m;
        x    = xx;
        it.id  = next_id;
        it.sel = sel;
        it.y   = ey;
        it.c   = ec;
        it.v   = ev;
        it.w   = ew;
        sb.push_back(it);
        next_id++;
    endtask

    task automatic scan_run(input int k0, input int k1, input logic sel, input int d, input int sc);
        out_t o;
        logic [1:0] rx;
        for (int k = k0; k <= k1; k++) begin
            o  = scan_exp(k, d, sc);
            rx = 2'($urandom_range(0, 3));
            step(1'b0, 1'b1, 1'b1, rx, sel, o.y, o.c, o.v, o.w);
        end
    endtask

    // Compare DUT outputs shortly after each rising edge against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("y",     cur.id, cur.sel ? y_b : y_a, cur.y);
            chk("code",  cur.id, {2'b00, cur.sel ? code_b : code_a}, {2'b00, cur.c});
            chk("valid", cur.id, {3'b000, cur.sel ? valid_b : valid_a}, {3'b000, cur.v});
            chk("wrap",  cur.id, {3'b000, cur.sel ? wrap_b : wrap_a}, {3'b000, cur.w});
            chk("v_or_y", cur.id, {3'b000, cur.sel ? valid_b : valid_a},
                {3'b000, cur.sel ? (|y_b) : (|y_a)});
        end
    end

    initial begin
        vec_t tbl[11];
        out_t o;

        rst  = 1'b1;
        e    = 1'b0;
        mode = 1'b0;
        x    = 2'd0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].en, tbl[i].m, tbl[i].xx, 1'b0,
                 tbl[i].y, tbl[i].c, tbl[i].v, tbl[i].w);
        end

        // Full scan from idle, through the wrap back to index 0.
        scan_run(0, 19, 1'b0, 4, 4);
        o = scan_exp(19, 4, 4);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, o.c, 1'b0, 1'b0);

        // Enable drops at index 2, then re-enable restarts at 0.
        scan_run(0, 8, 1'b0, 4, 4);
        step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
        scan_run(0, 12, 1'b0, 4, 4);

        // Reset at index 3 with scan still requested, then restart.
        step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        scan_run(0, 5, 1'b0, 4, 4);

        // Mode toggle: direct decode, then scan restarts with a cleared dwell counter.
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        scan_run(0, 4, 1'b0, 4, 4);
        o = scan_exp(4, 4, 4);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, o.c, 1'b0, 1'b0);

        // Short scan on the SCAN_COUNT=3 instance.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        scan_run(0, 11, 1'b1, DWELL_B, 3);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
